// File: rtl/hmmm_muldiv.sv
// hmmm_muldiv: iterative signed multiply / divide / modulo unit for the Hmmm core.
// It works on operand magnitudes and resolves one bit per clock: shift-add for
// mul, restoring division for div/mod. Signs are applied in FIX.
// Results and flags for ops 2/3/4 match the combinational alu.
// Optional build macro HMMM_MULDIV_DIVZERO_EN adds the div_by_zero output.
//
//   state | meaning
//   IDLE  | waiting for start; latches operands, magnitudes and signs
//   CALC  | one shift-add / restoring-divide step per clock, WIDTH clocks
//   FIX   | sign correction; result/zero/carry written
//   DONE  | raises done for the next cycle and clears busy
module hmmm_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] tmp1,
  input  logic [WIDTH-1:0] tmp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
`ifdef HMMM_MULDIV_DIVZERO_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int              PW     = 2 * WIDTH;
  localparam logic [2:0]      OP_MUL = 3'd2;
  localparam logic [2:0]      OP_DIV = 3'd3;
  localparam logic [2:0]      OP_MOD = 3'd4;
  localparam logic [PW-1:0]   HALF   = PW'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_a, sign_b;
  logic             div0_q;
  logic [CNT_W-1:0] cnt;
  // mul: {partial product high half, multiplier bits still to consume}
  // div: {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [PW-1:0]    acc;

  // request decode on the live inputs
  logic             op_legal, div0_in, fast;
  logic [WIDTH-1:0] abs_a, abs_b;

  // iteration datapath
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [PW-1:0]    div_next;

  // sign fix-up
  logic             neg;
  logic [WIDTH-1:0] prod_lo, quot_s, rem_s;
  logic             mul_ovf, div_ovf;
  logic [WIDTH-1:0] fix_res;
  logic             fix_carry;

  // Decode the request and form unsigned magnitudes (-2^(WIDTH-1) maps to 2^(WIDTH-1)).
  always_comb begin
    op_legal = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    div0_in  = ((op == OP_DIV) || (op == OP_MOD)) && (tmp2 == '0);
    fast     = !op_legal || div0_in;
    abs_a    = tmp1[WIDTH-1] ? (~tmp1 + 1'b1) : tmp1;
    abs_b    = tmp2[WIDTH-1] ? (~tmp2 + 1'b1) : tmp2;
  end

  // One multiply step and one restoring-divide step, selected later by op_q.
  always_comb begin
    mul_sum   = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[PW-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    // when div_ge holds the difference is below mag_b, so WIDTH bits suffice
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
    div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Apply signs to the magnitude result and derive the carry flag.
  always_comb begin
    neg       = sign_a ^ sign_b;
    prod_lo   = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    // a negative product may reach -2^(WIDTH-1), a positive one only 2^(WIDTH-1)-1
    mul_ovf   = neg ? (acc > HALF) : (acc >= HALF);
    quot_s    = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    // quotient magnitude 2^(WIDTH-1) with positive sign only comes from MIN / -1
    div_ovf   = !neg && acc[WIDTH-1];
    rem_s     = sign_a ? (~acc[PW-1:WIDTH] + 1'b1) : acc[PW-1:WIDTH];
    fix_res   = '0;
    fix_carry = 1'b0;
    if (div0_q) begin
      fix_carry = 1'b1;
    end else begin
      case (op_q)
        OP_MUL: begin
          fix_res   = prod_lo;
          fix_carry = mul_ovf;
        end
        OP_DIV: begin
          fix_res   = quot_s;
          fix_carry = div_ovf;
        end
        OP_MOD: fix_res = rem_s;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; illegal ops and zero divisors skip CALC.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = fast ? FIX : CALC;
      CALC:    if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration registers and held outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      div0_q      <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
`ifdef HMMM_MULDIV_DIVZERO_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            sign_a <= tmp1[WIDTH-1];
            sign_b <= tmp2[WIDTH-1];
            div0_q <= div0_in;
            cnt    <= '0;
            acc    <= (op == OP_MUL) ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
            busy   <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= (op_q == OP_MUL) ? mul_next : div_next;
        end
        FIX: begin
          result      <= fix_res;
          zero        <= (fix_res == '0);
          carry       <= fix_carry;
`ifdef HMMM_MULDIV_DIVZERO_EN
          div_by_zero <= div0_q;
`endif
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmmm_muldiv.sv
// Directed testbench for hmmm_muldiv: a vector table for single operations plus
// hand-written sequences for held start, mid-operation reset and start after done.
module tb_hmmm_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] tmp1, tmp2;
  logic        busy, done, zero, carry;
  logic [15:0] result;
`ifdef HMMM_MULDIV_DIVZERO_EN
  logic        div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  hmmm_muldiv #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .tmp1(tmp1),
    .tmp2(tmp2),
    .busy(busy),
    .done(done),
    .result(result),
    .zero(zero),
    .carry(carry)
`ifdef HMMM_MULDIV_DIVZERO_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        dbz;
    int          lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // One start pulse, operands scrambled after the accepting edge, done awaited with a bound.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ez,
                        input logic ec, input logic edbz, input int elat);
    int seen;
    logic [15:0] r;
    logic z, c;
    logic d;
    @(negedge clk);
    start = 1'b1; op = o; tmp1 = a; tmp2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    tmp1 = 16'($urandom);
    tmp2 = 16'($urandom);
    op   = 3'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    seen = -1; r = 'x; z = 1'bx; c = 1'bx; d = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = k; r = result; z = zero; c = carry;
`ifdef HMMM_MULDIV_DIVZERO_EN
        d = div_by_zero;
`endif
        break;
      end
    end
    chk({tag, " latency"}, 32'(seen), 32'(elat));
    chk({tag, " result"}, 32'(r), 32'(er));
    chk({tag, " zero"}, 32'(z), 32'(ez));
    chk({tag, " carry"}, 32'(c), 32'(ec));
`ifdef HMMM_MULDIV_DIVZERO_EN
    chk({tag, " div_by_zero"}, 32'(d), 32'(edbz));
`else
    d = edbz;
`endif
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n_done, busy_low, k_done, seen;
    logic [15:0] r;

    vecs[0]  = '{3'd2, 16'd3,      16'hFFFE, 16'hFFFA, 1'b0, 1'b0, 1'b0, 18};
    vecs[1]  = '{3'd2, 16'd300,    16'd200,  16'hEA60, 1'b0, 1'b1, 1'b0, 18};
    vecs[2]  = '{3'd2, 16'hFFFD,   16'hFFFE, 16'd6,    1'b0, 1'b0, 1'b0, 18};
    vecs[3]  = '{3'd3, 16'hFFF1,   16'd3,    16'hFFFB, 1'b0, 1'b0, 1'b0, 18};
    vecs[4]  = '{3'd3, 16'd15,     16'hFFFD, 16'hFFFB, 1'b0, 1'b0, 1'b0, 18};
    vecs[5]  = '{3'd4, 16'hFFF4,   16'd5,    16'hFFFE, 1'b0, 1'b0, 1'b0, 18};
    vecs[6]  = '{3'd4, 16'd12,     16'hFFFB, 16'd2,    1'b0, 1'b0, 1'b0, 18};
    vecs[7]  = '{3'd4, 16'd12,     16'd3,    16'd0,    1'b1, 1'b0, 1'b0, 18};
    vecs[8]  = '{3'd3, 16'h8000,   16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0, 18};
    vecs[9]  = '{3'd3, 16'd7,      16'd0,    16'd0,    1'b1, 1'b1, 1'b1, 2};
    vecs[10] = '{3'd2, 16'd9,      16'd9,    16'd81,   1'b0, 1'b0, 1'b0, 18};
    vecs[11] = '{3'd5, 16'd9,      16'd9,    16'd0,    1'b1, 1'b0, 1'b0, 2};
    vecs[12] = '{3'd2, 16'h8000,   16'd1,    16'h8000, 1'b0, 1'b0, 1'b0, 18};
    vecs[13] = '{3'd2, 16'h8000,   16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0, 18};
    vecs[14] = '{3'd2, 16'd0,      16'd5,    16'd0,    1'b1, 1'b0, 1'b0, 18};
    vecs[15] = '{3'd3, 16'h8000,   16'd1,    16'h8000, 1'b0, 1'b0, 1'b0, 18};
    vecs[16] = '{3'd3, 16'd7,      16'hFFFE, 16'hFFFD, 1'b0, 1'b0, 1'b0, 18};
    vecs[17] = '{3'd4, 16'hFFF9,   16'd2,    16'hFFFF, 1'b0, 1'b0, 1'b0, 18};
    vecs[18] = '{3'd4, 16'd5,      16'd0,    16'd0,    1'b1, 1'b1, 1'b1, 2};

    reset = 1'b1; start = 1'b0; op = '0; tmp1 = '0; tmp2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset zero", 32'(zero), 32'd0);
    chk("reset carry", 32'(carry), 32'd0);
`ifdef HMMM_MULDIV_DIVZERO_EN
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].dbz, vecs[i].lat);
    end

    // start held high the whole time, operands changed mid-CALC
    @(negedge clk);
    start = 1'b1; op = 3'd2; tmp1 = 16'd7; tmp2 = 16'd5;
    @(posedge clk); #1;
    chk("held busy", 32'(busy), 32'd1);
    n_done = 0; busy_low = 0; k_done = -1; r = 'x;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        op = 3'd3; tmp1 = 16'd123; tmp2 = 16'hFFF7;
      end
      if (done) begin
        n_done++; k_done = k; r = result;
      end
      if (k < 18 && !busy) busy_low++;
    end
    chk("held done count", 32'(n_done), 32'd1);
    chk("held done cycle", 32'(k_done), 32'd18);
    chk("held busy gaps", 32'(busy_low), 32'd0);
    chk("held result", 32'(r), 32'd35);
    // the still-high start is taken only now that the unit is back in IDLE
    @(posedge clk); #1;
    chk("held restart busy", 32'(busy), 32'd1);
    start = 1'b0;
    seen = -1; r = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = k; r = result; break;
      end
    end
    chk("held second latency", 32'(seen), 32'd18);
    chk("held second result", 32'(r), 32'hFFF3);

    // reset in cycle 8 of CALC
    @(negedge clk);
    start = 1'b1; op = 3'd2; tmp1 = 16'd1234; tmp2 = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort zero", 32'(zero), 32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    chk("abort stray activity", 32'(n_done), 32'd0);
    run_op("after abort", 3'd2, 16'd1234, 16'd3, 16'd3702, 1'b0, 1'b0, 1'b0, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
